hack_pc_jump: RTL and testbench

//   Hack CPU program-counter stage with integrated jump-condition evaluation.

---
 rtl/hack_pc_jump.sv | 76 +++++++
 tb/tb_hack_pc_jump.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/hack_pc_jump.sv
// hack_pc_jump -- Hack CPU program-counter stage with jump-condition evaluation.
//
// Takes the current instruction, the A register and the ALU flags and
// produces the next ROM fetch address. The PC reloads from a_reg on a taken
// jump, increments (wrapping modulo 2^WIDTH) otherwise, and holds when en=0.
//
// Optional build macro: HACK_PC_HALT_DETECT_EN
//   defined   -> halted sets on a taken jump whose target equals the current
//                pc (the Hack end-of-program self-loop) and stays set until
//                reset. It does not stop the pc from reloading.
//   undefined -> halted is tied low; the port list is unchanged.
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   asynchronous, active-high reset
//   en          in   advance enable (0 = stall, pc holds)
//   instr       in   [15] C-type flag, [2:0] jump bits j1 j2 j3
//   a_reg       in   jump target
//   zr, ng      in   ALU result zero / negative flags
//   pc          out  registered program counter
//   jump_taken  out  registered, high for the cycle after a taken jump
//   halted      out  sticky self-loop flag (see macro above)

module hack_pc_jump #(
   parameter int               WIDTH        = 16,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [15:0]      instr,
   input  logic [WIDTH-1:0] a_reg,
   input  logic             zr,
   input  logic             ng,
   output logic [WIDTH-1:0] pc,
   output logic             jump_taken,
   output logic             halted
);

   logic pos;
   logic jmp;

   // zr=ng=1 is not a legal ALU state; it is evaluated as-is.
   assign pos = ~zr & ~ng;
   assign jmp = instr[15] & ((instr[2] & ng) | (instr[1] & zr) | (instr[0] & pos));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc         <= RESET_VECTOR;
         jump_taken <= 1'b0;
      end else if (en) begin
         if (jmp) begin
            pc         <= a_reg;
            jump_taken <= 1'b1;
         end else begin
            pc         <= pc + 1'b1;
            jump_taken <= 1'b0;
         end
      end else begin
         jump_taken <= 1'b0;
      end
   end

`ifdef HACK_PC_HALT_DETECT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         halted <= 1'b0;
      end else if (en && jmp && (a_reg == pc)) begin
         halted <= 1'b1;
      end
   end
`else
   assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_hack_pc_jump.sv
// Bench for hack_pc_jump: directed cases with literal expectations plus a
// randomized run, all checked every cycle against a behavioural model.

module tb_hack_pc_jump;

   localparam int W = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          en;
   logic [15:0]   instr;
   logic [W-1:0]  a_reg;
   logic          zr;
   logic          ng;
   logic [W-1:0]  pc;
   logic          jump_taken;
   logic          halted;

   int n_cmp = 0;
   int n_err = 0;

   // behavioural model state
   logic [W-1:0]  m_pc;
   logic          m_jt;
   logic          m_h;

`ifdef HACK_PC_HALT_DETECT_EN
   localparam bit HALT_EN = 1'b1;
`else
   localparam bit HALT_EN = 1'b0;
`endif

   hack_pc_jump #(.WIDTH(W), .RESET_VECTOR(16'h0000)) dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .instr      (instr),
      .a_reg      (a_reg),
      .zr         (zr),
      .ng         (ng),
      .pc         (pc),
      .jump_taken (jump_taken),
      .halted     (halted)
   );

   always #5 clk = ~clk;

   // Hack jump semantics: j1 -> jump if out<0, j2 -> if out==0, j3 -> if out>0.
   function automatic bit taken_rule(input logic [15:0] ins, input logic z, input logic n);
      bit lt, eq, gt;
      lt = n;
      eq = z;
      gt = !z && !n;
      if (!ins[15]) return 1'b0;
      return (ins[2] && lt) || (ins[1] && eq) || (ins[0] && gt);
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_pc = 16'h0000;
         m_jt = 1'b0;
         m_h  = 1'b0;
      end else if (en) begin
         if (taken_rule(instr, zr, ng)) begin
            if (HALT_EN && a_reg == m_pc) m_h = 1'b1;
            m_pc = a_reg;
            m_jt = 1'b1;
         end else begin
            m_pc = (m_pc + 1) % 65536;
            m_jt = 1'b0;
         end
      end else begin
         m_jt = 1'b0;
      end
   end

   // every-cycle compare against the model
   always @(negedge clk) begin
      n_cmp++;
      if (pc !== m_pc || jump_taken !== m_jt || halted !== m_h) begin
         n_err++;
         $display("FAIL model_cmp t=%0t: got pc=%h jt=%b h=%b, want pc=%h jt=%b h=%b",
                  $time, pc, jump_taken, halted, m_pc, m_jt, m_h);
      end
   end

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic step(input logic e, input logic [15:0] ins, input logic [W-1:0] a,
                       input logic z, input logic n);
      en    = e;
      instr = ins;
      a_reg = a;
      zr    = z;
      ng    = n;
      @(negedge clk);
   endtask

   task automatic goto(input logic [W-1:0] target);
      step(1'b1, 16'hE007, target, 1'b0, 1'b0);
   endtask

   initial begin
      logic [W-1:0] base;
      bit           exp_t;
      logic         z, n;

      reset = 1'b1; en = 1'b0; instr = '0; a_reg = '0; zr = 1'b0; ng = 1'b0;
      @(negedge clk);
      check("reset_pc", pc, 16'h0000);
      check("reset_jt", {15'd0, jump_taken}, 16'd0);
      check("reset_halted", {15'd0, halted}, 16'd0);
      reset = 1'b0;

      // 2: A-instruction increments from 0
      step(1'b1, 16'h0005, 16'h1234, 1'b0, 1'b0);
      check("inc_1", pc, 16'h0001);
      step(1'b1, 16'h0005, 16'h1234, 1'b0, 1'b0);
      check("inc_2", pc, 16'h0002);
      step(1'b1, 16'h0005, 16'h1234, 1'b1, 1'b0);
      check("inc_3", pc, 16'h0003);
      check("inc_jt", {15'd0, jump_taken}, 16'd0);

      // 1: asynchronous reset mid-run
      goto(16'h0123);
      check("pre_reset_pc", pc, 16'h0123);
      #2 reset = 1'b1;
      #1;
      check("async_reset_pc", pc, 16'h0000);
      check("async_reset_jt", {15'd0, jump_taken}, 16'd0);
      @(negedge clk);
      reset = 1'b0;

      // 3: JEQ taken and not taken
      goto(16'h0010);
      step(1'b1, 16'hE302, 16'h0040, 1'b1, 1'b0);
      check("jeq_taken_pc", pc, 16'h0040);
      check("jeq_taken_jt", {15'd0, jump_taken}, 16'd1);
      step(1'b0, 16'hE302, 16'h0040, 1'b1, 1'b0);
      check("jt_one_cycle", {15'd0, jump_taken}, 16'd0);
      check("stall_hold", pc, 16'h0040);
      goto(16'h0010);
      step(1'b1, 16'hE302, 16'h0040, 1'b0, 1'b0);
      check("jeq_not_taken_pc", pc, 16'h0011);

      // 4: sweep jump bits against legal flag combinations
      base = 16'h0100;
      for (int j = 0; j < 8; j++) begin
         for (int f = 0; f < 3; f++) begin
            z = (f == 1);
            n = (f == 2);
            exp_t = ((j & 4) != 0 && n) || ((j & 2) != 0 && z) || ((j & 1) != 0 && !z && !n);
            goto(base);
            step(1'b1, 16'hE300 | 16'(j), 16'h0ABC, z, n);
            check($sformatf("sweep_j%0d_f%0d", j, f), pc, exp_t ? 16'h0ABC : 16'h0101);
         end
      end
      // illegal zr=ng=1 follows the formula
      goto(base);
      step(1'b1, 16'hE301, 16'h0ABC, 1'b1, 1'b1);
      check("illegal_jgt", pc, 16'h0101);
      // A-type with jump bits set never jumps
      goto(base);
      step(1'b1, 16'h0007, 16'h0ABC, 1'b0, 1'b0);
      check("atype_no_jump", pc, 16'h0101);

      // 5: wrap and stall
      goto(16'hFFFF);
      step(1'b1, 16'h0000, 16'h5555, 1'b0, 1'b0);
      check("wrap", pc, 16'h0000);
      for (int k = 0; k < 4; k++) begin
         step(1'b0, 16'hE007, 16'h5555, 1'b0, 1'b0);
         check("stall_pc", pc, 16'h0000);
         check("stall_jt", {15'd0, jump_taken}, 16'd0);
      end

      // 6: self-loop halt detection
      goto(16'h0020);
      check("pre_halt", {15'd0, halted}, 16'd0);
      step(1'b1, 16'hEA87, 16'h0020, 1'b0, 1'b0);
      check("halt_pc", pc, 16'h0020);
      check("halt_set", {15'd0, halted}, {15'd0, HALT_EN});
      step(1'b1, 16'h0001, 16'h0000, 1'b0, 1'b0);
      step(1'b0, 16'h0001, 16'h0000, 1'b0, 1'b0);
      check("halt_sticky", {15'd0, halted}, {15'd0, HALT_EN});
      reset = 1'b1;
      #1;
      check("halt_cleared", {15'd0, halted}, 16'd0);
      @(negedge clk);
      reset = 1'b0;

      // randomized run
      for (int i = 0; i < 3000; i++) begin
         logic [W-1:0] a;
         a = ($urandom_range(0, 7) == 0) ? m_pc : W'($urandom);
         if ($urandom_range(0, 199) == 0) begin
            #($urandom_range(1, 4)) reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
         end else begin
            step($urandom_range(0, 9) != 0, 16'($urandom), a,
                 1'($urandom), 1'($urandom));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
